mig_write_coalescer: RTL and testbench

- Parametrised successor to the framebuffer's MIG write-request stage. Takes a pixel stream (hcount, vcount, color, frame) from the rasterizer and packs pixels that fall in the same DRAM beat into one BEAT_W-bit write request with per-byte strobes.
- Adds four features: width/depth generalisation, a double-buffer frame offset, early close on flush or idle timeout, and suppression of all-masked beats.
- Sits between the rasterizer and the MIG write-command FIFO.

---
 rtl/mig_write_coalescer.sv | 194 +++++++++++++++++++
 tb/tb_mig_write_coalescer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mig_write_coalescer.sv
// mig_write_coalescer
//   Packs rasterizer pixels that land in the same DRAM beat into one BEAT_W
//   write request with per-byte strobes, for the MIG write-command FIFO.
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   hcount/vcount/color     pixel position and value
//   frame                   destination buffer (adds FRAME_STRIDE)
//   mask_in                 pixel accepted but sets no strobe
//   valid_in / rdy_out      pixel handshake (rdy_out = output slot free)
//   flush_in                force-close any open beat
//   rdy_in / valid_out      request handshake with the downstream FIFO
//   addr_out/data_out/strobe_out  request payload
//   idle_out                no open beat and no pending request
module mig_write_coalescer #(
  parameter int unsigned HRES         = 320,
  parameter int unsigned VRES         = 180,
  parameter int unsigned PIX_W        = 16,
  parameter int unsigned BEAT_W       = 128,
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned FRAME_STRIDE = 131072,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [$clog2(HRES)-1:0]    hcount,
  input  logic [$clog2(VRES)-1:0]    vcount,
  input  logic [PIX_W-1:0]           color,
  input  logic                       frame,
  input  logic                       mask_in,
  input  logic                       valid_in,
  output logic                       rdy_out,
  input  logic                       flush_in,
  input  logic                       rdy_in,
  output logic                       valid_out,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [BEAT_W-1:0]          data_out,
  output logic [BEAT_W/8-1:0]        strobe_out,
  output logic                       idle_out
);

  localparam int unsigned PPB = BEAT_W / PIX_W;
  localparam int unsigned BPB = BEAT_W / 8;
  localparam int unsigned SPP = PIX_W / 8;
  localparam int unsigned IW  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {EMPTY, ACCUM} state_t;

  state_t             state_q, state_d;
  logic               tag_frame_q, tag_frame_d;
  logic [31:0]        tag_beat_q, tag_beat_d;
  logic [BEAT_W-1:0]  acc_data_q, acc_data_d;
  logic [BPB-1:0]     acc_strb_q, acc_strb_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               pend_q, pend_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic [BEAT_W-1:0]  out_data_q, out_data_d;
  logic [BPB-1:0]     out_strb_q, out_strb_d;

  logic               slot_free, accept, timeout_hit, same_tag, slot_used, close_req;
  logic [31:0]        pix_p, pix_beat, pix_lane;
  logic [BEAT_W-1:0]  w_data;
  logic [BPB-1:0]     w_strb;

  function automatic logic [ADDR_W-1:0] addr_of(input logic f, input logic [31:0] b);
    return ADDR_W'(b) * ADDR_W'(BPB) + (f ? ADDR_W'(FRAME_STRIDE) : '0);
  endfunction

  assign slot_free   = !out_valid_q || rdy_in;
  assign rdy_out     = slot_free;
  assign accept      = valid_in && slot_free;
  assign pix_p       = 32'(vcount) * 32'(HRES) + 32'(hcount);
  assign pix_beat    = pix_p / 32'(PPB);
  assign pix_lane    = pix_p % 32'(PPB);
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_q == IW'(IDLE_TIMEOUT));
  assign same_tag    = (state_q == ACCUM) && (tag_frame_q == frame) && (tag_beat_q == pix_beat);

  assign valid_out  = out_valid_q;
  assign addr_out   = out_addr_q;
  assign data_out   = out_data_q;
  assign strobe_out = out_strb_q;
  assign idle_out   = (state_q == EMPTY) && !out_valid_q;

  always_comb begin
    state_d     = state_q;
    tag_frame_d = tag_frame_q;
    tag_beat_d  = tag_beat_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    idle_d      = idle_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q && !rdy_in;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    slot_used   = 1'b0;
    close_req   = 1'b0;
    w_data      = '0;
    w_strb      = '0;

    if (accept) begin
      idle_d = '0;
      // Tag change: retire the old beat into the (free) slot first.
      if ((state_q == ACCUM) && !same_tag && (acc_strb_q != '0)) begin
        out_valid_d = 1'b1;
        out_addr_d  = addr_of(tag_frame_q, tag_beat_q);
        out_data_d  = acc_data_q;
        out_strb_d  = acc_strb_q;
        slot_used   = 1'b1;
      end
      if (same_tag) begin
        w_data    = acc_data_q;
        w_strb    = acc_strb_q;
        close_req = pend_q;
      end
      if (!mask_in) begin
        for (int unsigned l = 0; l < PPB; l++) begin
          if (pix_lane == l) begin
            w_data[l*PIX_W +: PIX_W] = color;
            w_strb[l*SPP +: SPP]     = '1;
          end
        end
      end
      close_req = close_req || (pix_lane == 32'(PPB - 1)) || flush_in;
      pend_d    = 1'b0;
      if (close_req && !slot_used) begin
        if (w_strb != '0) begin
          out_valid_d = 1'b1;
          out_addr_d  = addr_of(frame, pix_beat);
          out_data_d  = w_data;
          out_strb_d  = w_strb;
        end
        state_d    = EMPTY;
        acc_data_d = '0;
        acc_strb_d = '0;
      end else begin
        // Slot already taken by the retired beat: keep this one open and
        // let the pending flag close it once the slot frees up.
        state_d     = ACCUM;
        tag_frame_d = frame;
        tag_beat_d  = pix_beat;
        acc_data_d  = w_data;
        acc_strb_d  = w_strb;
        pend_d      = close_req;
      end
    end else if (state_q == ACCUM) begin
      if ((flush_in || timeout_hit || pend_q) && slot_free) begin
        if (acc_strb_q != '0) begin
          out_valid_d = 1'b1;
          out_addr_d  = addr_of(tag_frame_q, tag_beat_q);
          out_data_d  = acc_data_q;
          out_strb_d  = acc_strb_q;
        end
        state_d    = EMPTY;
        acc_data_d = '0;
        acc_strb_d = '0;
        idle_d     = '0;
        pend_d     = 1'b0;
      end else begin
        if (flush_in || timeout_hit) pend_d = 1'b1;
        if (idle_q != IW'(IDLE_TIMEOUT)) idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= EMPTY;
      tag_frame_q <= 1'b0;
      tag_beat_q  <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      idle_q      <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      state_q     <= state_d;
      tag_frame_q <= tag_frame_d;
      tag_beat_q  <= tag_beat_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      idle_q      <= idle_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
    end
  end

endmodule

// File: tb/tb_mig_write_coalescer.sv
module tb_mig_write_coalescer;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [8:0]   hcount;
  logic [7:0]   vcount;
  logic [15:0]  color;
  logic         frame;
  logic         mask_in;
  logic         valid_in;
  logic         rdy_out;
  logic         flush_in;
  logic         rdy_in;
  logic         valid_out;
  logic [26:0]  addr_out;
  logic [127:0] data_out;
  logic [15:0]  strobe_out;
  logic         idle_out;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_data;
  logic [26:0]  hold_addr;
  logic [127:0] hold_data;
  logic [15:0]  hold_strb;

  mig_write_coalescer #(
    .HRES(320), .VRES(180), .PIX_W(16), .BEAT_W(128), .ADDR_W(27),
    .FRAME_STRIDE(131072), .IDLE_TIMEOUT(32)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount(hcount), .vcount(vcount),
    .color(color), .frame(frame), .mask_in(mask_in), .valid_in(valid_in),
    .rdy_out(rdy_out), .flush_in(flush_in), .rdy_in(rdy_in),
    .valid_out(valid_out), .addr_out(addr_out), .data_out(data_out),
    .strobe_out(strobe_out), .idle_out(idle_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic [15:0] c, input logic f, input logic m);
    hcount   = 9'(h);
    vcount   = 8'(v);
    color    = c;
    frame    = f;
    mask_in  = m;
    valid_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b1; hcount = '0; vcount = '0; color = '0; frame = 1'b0;
    mask_in = 1'b0; valid_in = 1'b0; flush_in = 1'b0; rdy_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    #1;
    chk("rst_valid", 128'(valid_out), 128'(1'b0));
    chk("rst_addr", 128'(addr_out), 128'(0));
    chk("rst_data", data_out, 128'(0));
    chk("rst_strobe", 128'(strobe_out), 128'(0));
    chk("rst_rdy", 128'(rdy_out), 128'(1'b1));
    chk("rst_idle", 128'(idle_out), 128'(1'b1));
    rdy_in = 1'b1;

    // 1. full beat
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      pix(i, 0, 16'h1000 + 16'(i), 1'b0, 1'b0);
      exp_data[i*16 +: 16] = 16'h1000 + 16'(i);
      tick();
      if (i < 7) chk("full_nopre", 128'(valid_out), 128'(1'b0));
    end
    valid_in = 1'b0;
    chk("full_valid", 128'(valid_out), 128'(1'b1));
    chk("full_addr", 128'(addr_out), 128'(27'h0));
    chk("full_strobe", 128'(strobe_out), 128'(16'hFFFF));
    chk("full_data", data_out, exp_data);
    tick();
    chk("full_xfer", 128'(valid_out), 128'(1'b0));
    chk("full_idle", 128'(idle_out), 128'(1'b1));

    // 2. partial beat closed by tag change
    pix(10, 0, 16'hAAAA, 1'b0, 1'b0); tick();
    pix(11, 0, 16'hBBBB, 1'b0, 1'b0); tick();
    chk("part_nopre", 128'(valid_out), 128'(1'b0));
    pix(40, 0, 16'hCCCC, 1'b0, 1'b0); tick();
    valid_in = 1'b0;
    chk("part_valid", 128'(valid_out), 128'(1'b1));
    chk("part_addr", 128'(addr_out), 128'(27'h10));
    chk("part_strobe", 128'(strobe_out), 128'(16'h00F0));
    chk("part_lanes23", 128'(data_out[63:32]), 128'(32'hBBBB_AAAA));
    tick();
    chk("part_xfer", 128'(valid_out), 128'(1'b0));
    chk("part_open", 128'(idle_out), 128'(1'b0));
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    chk("part2_valid", 128'(valid_out), 128'(1'b1));
    chk("part2_addr", 128'(addr_out), 128'(27'h50));
    chk("part2_strobe", 128'(strobe_out), 128'(16'h0003));
    chk("part2_lane0", 128'(data_out[15:0]), 128'(16'hCCCC));
    tick();
    chk("part2_idle", 128'(idle_out), 128'(1'b1));

    // 3. masking
    for (int i = 0; i < 8; i++) begin
      pix(i, 0, 16'hEE00 + 16'(i), 1'b0, 1'b1);
      tick();
      chk("mask_none", 128'(valid_out), 128'(1'b0));
    end
    valid_in = 1'b0;
    chk("mask_idle", 128'(idle_out), 128'(1'b1));
    for (int i = 0; i < 8; i++) begin
      pix(i, 0, (i == 5) ? 16'h5555 : 16'hEE00, 1'b0, (i != 5));
      tick();
    end
    valid_in = 1'b0;
    chk("mask5_valid", 128'(valid_out), 128'(1'b1));
    chk("mask5_addr", 128'(addr_out), 128'(27'h0));
    chk("mask5_strobe", 128'(strobe_out), 128'(16'h0C00));
    chk("mask5_lane5", 128'(data_out[95:80]), 128'(16'h5555));
    tick();

    // 4. backpressure
    rdy_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pix(i, 2, 16'h2000 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    chk("bp_valid", 128'(valid_out), 128'(1'b1));
    chk("bp_addr", 128'(addr_out), 128'(27'h500));
    hold_addr = addr_out; hold_data = data_out; hold_strb = strobe_out;
    pix(8, 2, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_rdy_low", 128'(rdy_out), 128'(1'b0));
      tick();
      chk("bp_hold_v", 128'(valid_out), 128'(1'b1));
      chk("bp_hold_a", 128'(addr_out), 128'(hold_addr));
      chk("bp_hold_d", data_out, hold_data);
      chk("bp_hold_s", 128'(strobe_out), 128'(hold_strb));
    end
    chk("bp_idle", 128'(idle_out), 128'(1'b0));
    rdy_in = 1'b1;
    #1;
    chk("bp_rdy_high", 128'(rdy_out), 128'(1'b1));
    tick();
    valid_in = 1'b0;
    chk("bp_xfer", 128'(valid_out), 128'(1'b0));
    chk("bp_accepted", 128'(idle_out), 128'(1'b0));
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    chk("bp_px_valid", 128'(valid_out), 128'(1'b1));
    chk("bp_px_addr", 128'(addr_out), 128'(27'h510));
    chk("bp_px_strobe", 128'(strobe_out), 128'(16'h0003));
    chk("bp_px_lane0", 128'(data_out[15:0]), 128'(16'h3333));
    tick();

    // 5. idle timeout then flush
    pix(3, 1, 16'h7777, 1'b0, 1'b0); tick();
    valid_in = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("to_wait", 128'(valid_out), 128'(1'b0));
    end
    tick();
    chk("to_valid", 128'(valid_out), 128'(1'b1));
    chk("to_addr", 128'(addr_out), 128'(27'h280));
    chk("to_strobe", 128'(strobe_out), 128'(16'h00C0));
    chk("to_lane3", 128'(data_out[63:48]), 128'(16'h7777));
    tick();
    pix(3, 1, 16'h8888, 1'b0, 1'b0); tick();
    valid_in = 1'b0;
    tick(); tick();
    chk("fl_wait", 128'(valid_out), 128'(1'b0));
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    chk("fl_valid", 128'(valid_out), 128'(1'b1));
    chk("fl_addr", 128'(addr_out), 128'(27'h280));
    chk("fl_lane3", 128'(data_out[63:48]), 128'(16'h8888));
    tick();

    // 6. frame offset, then reset mid-beat
    pix(0, 0, 16'h9999, 1'b1, 1'b0);
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    valid_in = 1'b0;
    chk("fr_valid", 128'(valid_out), 128'(1'b1));
    chk("fr_addr", 128'(addr_out), 128'(27'h20000));
    chk("fr_strobe", 128'(strobe_out), 128'(16'h0003));
    tick();
    for (int i = 0; i < 3; i++) begin
      pix(i, 0, 16'h4000 + 16'(i), 1'b0, 1'b0);
      tick();
    end
    valid_in = 1'b0;
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    chk("rr_idle", 128'(idle_out), 128'(1'b1));
    chk("rr_rdy", 128'(rdy_out), 128'(1'b1));
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("rr_none", 128'(valid_out), 128'(1'b0));
    end
    chk("rr_idle_end", 128'(idle_out), 128'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
